// File: rtl/alu_issue_scheduler.sv
// Round-robin issue arbiter with a RAW/WAW scoreboard in front of a 3-stage pipelined ALU.
// Also provides a drain handshake that stops issue and reports when the pipeline is empty.
module alu_issue_scheduler #(
  parameter int unsigned NUM_REQ   = 4,
  parameter bit          RAW_CHECK = 1'b1,
  localparam int unsigned IdW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [5*NUM_REQ-1:0] req_a,
  input  logic [5*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_op,
  input  logic [5*NUM_REQ-1:0] req_dest,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_dest,
  input  logic                 drain_req,
  output logic                 issue_valid,
  output logic [4:0]           issue_a,
  output logic [4:0]           issue_b,
  output logic [1:0]           issue_op,
  output logic [4:0]           issue_dest,
  output logic [IdW-1:0]       issue_id,
  output logic [31:0]          busy_vec,
  output logic                 drain_done
);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e               state_q;
  logic [31:0]          busy_q, busy_d;
  logic [IdW-1:0]       rr_q, rr_d;
  logic [NUM_REQ-1:0]   elig;
  logic [NUM_REQ-1:0]   gnt;
  logic                 gnt_any;
  logic [IdW-1:0]       gnt_idx;
  logic [IdW-1:0]       cand_id;
  int                   cand;
  logic [4:0]           sel_a, sel_b, sel_dest;
  logic [1:0]           sel_op;

  // Reg 0 is never marked busy, so it can never create a hazard.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req_valid[i] & ~busy_q[req_dest[5*i +: 5]] &
                (~RAW_CHECK | (~busy_q[req_a[5*i +: 5]] & ~busy_q[req_b[5*i +: 5]]));
    end
  end

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    cand    = 0;
    cand_id = '0;
    if (state_q == StRun && !rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(rr_q) + k;
        if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
        cand_id = IdW'(cand);
        if (!gnt_any && elig[cand_id]) begin
          gnt_any = 1'b1;
          gnt_idx = cand_id;
        end
      end
    end
    gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
  end

  assign req_ready = gnt;
  assign busy_vec  = busy_q;

  always_comb begin
    sel_a    = req_a[5*gnt_idx +: 5];
    sel_b    = req_b[5*gnt_idx +: 5];
    sel_op   = req_op[2*gnt_idx +: 2];
    sel_dest = req_dest[5*gnt_idx +: 5];
  end

  // Clear before set so a coincident set of the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_dest] = 1'b0;
    if (gnt_any && sel_dest != 5'd0) busy_d[sel_dest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_any) rr_d = (int'(gnt_idx) == int'(NUM_REQ) - 1) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      busy_q      <= '0;
      rr_q        <= '0;
      issue_valid <= 1'b0;
      issue_a     <= '0;
      issue_b     <= '0;
      issue_op    <= '0;
      issue_dest  <= '0;
      issue_id    <= '0;
      drain_done  <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      rr_q        <= rr_d;
      issue_valid <= gnt_any;
      if (gnt_any) begin
        issue_a    <= sel_a;
        issue_b    <= sel_b;
        issue_op   <= sel_op;
        issue_dest <= sel_dest;
        issue_id   <= gnt_idx;
      end
      unique case (state_q)
        StRun: begin
          if (drain_req) state_q <= StDrain;
        end
        StDrain: begin
          if (!drain_req) begin
            state_q <= StRun;
          end else if (busy_q == '0 && !issue_valid) begin
            state_q    <= StDone;
            drain_done <= 1'b1;
          end
        end
        StDone: begin
          if (!drain_req) begin
            state_q    <= StRun;
            drain_done <= 1'b0;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

endmodule
